// File: rtl/synapse_accum_engine.sv
// synapse_accum_engine
// Per-tick synaptic integration engine. A tick latches the presynaptic spike
// vector. The engine then walks the pre neurons one per cycle. Pre neurons that
// did not spike are skipped after a single SCAN cycle. For a spiking pre neuron,
// its signed weight row is added into every postsynaptic membrane potential,
// one post neuron per ACCUM cycle, with saturation. A final FIRE cycle
// thresholds all potentials, resets the neurons that fired and publishes the
// output spike vector.
//
// Output handshake: spike_out_valid_o is a one-cycle, ready-less pulse.
// It is asserted in the cycle after FIRE. spike_out_o changes only on the edge
// that raises spike_out_valid_o, and it holds its value until the next FIRE.
// No backpressure exists, so a consumer must capture the vector while the
// pulse is high.
module synapse_accum_engine #(
  parameter int N_PRE     = 4,
  parameter int N_POST    = 4,
  parameter int W_WIDTH   = 4,
  parameter int ACC_WIDTH = 16,
  parameter int THRESHOLD = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                tick_i,
  input  logic [N_PRE-1:0]    spike_in_i,
  input  logic                w_wr_en_i,
  input  logic [((N_PRE*N_POST > 1) ? $clog2(N_PRE*N_POST) : 1)-1:0] w_wr_addr_i,
  input  logic [W_WIDTH-1:0]  w_wr_data_i,
  output logic                busy_o,
  output logic [N_POST-1:0]   spike_out_o,
  output logic                spike_out_valid_o,
  output logic                overrun_o,
  output logic [31:0]         dbg_pre_cnt_o,
  output logic [31:0]         dbg_post_cnt_o
);

  localparam int N_W    = N_PRE * N_POST;
  localparam int ADDR_W = (N_W > 1) ? $clog2(N_W) : 1;
  localparam int PRE_W  = (N_PRE > 1) ? $clog2(N_PRE) : 1;
  localparam int POST_W = (N_POST > 1) ? $clog2(N_POST) : 1;
  // Wide enough to hold both any potential and the threshold without truncation.
  localparam int CMP_W  = (ACC_WIDTH > 32) ? ACC_WIDTH + 1 : 33;

  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(N_PRE - 1);
  localparam logic [POST_W-1:0] POST_LAST = POST_W'(N_POST - 1);

  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic signed [CMP_W-1:0]     THR_EXT = CMP_W'(THRESHOLD);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SCAN  = 2'd1;
  localparam logic [1:0] S_ACCUM = 2'd2;
  localparam logic [1:0] S_FIRE  = 2'd3;

  // FSM and scan position
  logic [1:0]        state_q, state_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [POST_W-1:0] post_q, post_d;

  // Latched spikes, weights, potentials and outputs
  logic [N_PRE-1:0]            spk_q;
  logic [W_WIDTH-1:0]          w_mem [N_W];
  logic signed [ACC_WIDTH-1:0] v_q [N_POST];
  logic [N_POST-1:0]           spike_out_q;
  logic                        valid_q;
  logic                        overrun_q;

  // Datapath
  logic                        tick_accept;
  logic                        w_wr_accept;
  logic [ADDR_W-1:0]           rd_addr;
  logic signed [ACC_WIDTH-1:0] w_ext;
  logic signed [ACC_WIDTH-1:0] v_cur;
  logic signed [ACC_WIDTH:0]   v_sum_wide;
  logic signed [ACC_WIDTH-1:0] v_sum_sat;
  logic [N_POST-1:0]           fired;

  assign busy_o            = (state_q != S_IDLE);
  assign spike_out_o       = spike_out_q;
  assign spike_out_valid_o = valid_q;
  assign overrun_o         = overrun_q;
  assign dbg_pre_cnt_o     = 32'(pre_q);
  assign dbg_post_cnt_o    = 32'(post_q);

  // A tick is only acted upon in IDLE. Weight writes are dropped while a scan
  // runs, so the weights a scan sees are stable.
  assign tick_accept = tick_i && (state_q == S_IDLE);
  assign w_wr_accept = w_wr_en_i && !busy_o && (32'(w_wr_addr_i) < N_W);

  // Weight row-major address: pre * N_POST + post
  assign rd_addr = ADDR_W'(32'(pre_q) * N_POST + 32'(post_q));
  assign w_ext   = ACC_WIDTH'($signed(w_mem[rd_addr]));
  assign v_cur   = v_q[post_q];

  // Saturating add: one guard bit detects overflow, then clamp toward the sign of the true sum
  always_comb begin
    v_sum_wide = (ACC_WIDTH+1)'(v_cur) + (ACC_WIDTH+1)'(w_ext);
    if (v_sum_wide[ACC_WIDTH] != v_sum_wide[ACC_WIDTH-1]) begin
      v_sum_sat = v_sum_wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    end else begin
      v_sum_sat = v_sum_wide[ACC_WIDTH-1:0];
    end
  end

  // Threshold compare of every potential, used only in FIRE
  always_comb begin
    fired = '0;
    for (int p = 0; p < N_POST; p++) begin
      fired[p] = (CMP_W'(v_q[p]) >= THR_EXT);
    end
  end

  // Next-state and scan-index logic
  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    post_d  = post_q;
    case (state_q)
      S_IDLE: begin
        if (tick_i) begin
          state_d = S_SCAN;
          pre_d   = '0;
          post_d  = '0;
        end
      end
      S_SCAN: begin
        if (spk_q[pre_q]) begin
          state_d = S_ACCUM;
          post_d  = '0;
        end else if (pre_q == PRE_LAST) begin
          state_d = S_FIRE;
        end else begin
          pre_d = pre_q + 1'b1;
        end
      end
      S_ACCUM: begin
        if (post_q == POST_LAST) begin
          post_d = '0;
          if (pre_q == PRE_LAST) begin
            state_d = S_FIRE;
          end else begin
            pre_d   = pre_q + 1'b1;
            state_d = S_SCAN;
          end
        end else begin
          post_d = post_q + 1'b1;
        end
      end
      S_FIRE: begin
        state_d = S_IDLE;
        pre_d   = '0;
        post_d  = '0;
      end
      default: begin
        state_d = S_IDLE;
        pre_d   = '0;
        post_d  = '0;
      end
    endcase
  end

  // Control registers: FSM, spike latch, output vector, valid pulse, sticky overrun
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      pre_q       <= '0;
      post_q      <= '0;
      spk_q       <= '0;
      spike_out_q <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      post_q  <= post_d;
      valid_q <= (state_q == S_FIRE);
      if (tick_accept) begin
        spk_q <= spike_in_i;
      end
      if (state_q == S_FIRE) begin
        spike_out_q <= fired;
      end
      if (tick_i && busy_o) begin
        overrun_q <= 1'b1;
      end
    end
  end

  // Membrane potentials: one post neuron per ACCUM cycle; fired neurons cleared in FIRE
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int p = 0; p < N_POST; p++) begin
        v_q[p] <= '0;
      end
    end else if (state_q == S_ACCUM) begin
      v_q[post_q] <= v_sum_sat;
    end else if (state_q == S_FIRE) begin
      for (int p = 0; p < N_POST; p++) begin
        if (fired[p]) begin
          v_q[p] <= '0;
        end
      end
    end
  end

  // Weight RAM: not reset, so the contents survive rst_i
  always_ff @(posedge clk_i) begin
    if (w_wr_accept) begin
      w_mem[w_wr_addr_i] <= w_wr_data_i;
    end
  end

`ifndef SYNTHESIS
  // The valid pulse never lasts two cycles, because FIRE is never entered twice in a row
  a_valid_pulse: assert property (@(posedge clk_i) disable iff (rst_i)
    spike_out_valid_o |=> !spike_out_valid_o);

  // Only reset clears overrun
  a_overrun_sticky: assert property (@(posedge clk_i) disable iff (rst_i)
    overrun_o |=> overrun_o);

  // The scan index stays inside the pre range
  a_pre_range: assert property (@(posedge clk_i) disable iff (rst_i)
    32'(pre_q) < N_PRE);
`endif

endmodule

// File: tb/tb_synapse_accum_engine.sv
// Testbench for synapse_accum_engine.
// dut_a uses the default parameters.
// dut_b uses a narrow accumulator, which exercises saturation at both rails.
module tb_synapse_accum_engine;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- dut_a (defaults) ----------------
  logic        tick_a, wen_a;
  logic [3:0]  spk_a, waddr_a, wdata_a;
  logic        busy_a, valid_a, overrun_a;
  logic [3:0]  sout_a;
  logic [31:0] dbg_pre_a, dbg_post_a;

  synapse_accum_engine dut_a (
    .clk_i(clk), .rst_i(rst), .tick_i(tick_a), .spike_in_i(spk_a),
    .w_wr_en_i(wen_a), .w_wr_addr_i(waddr_a), .w_wr_data_i(wdata_a),
    .busy_o(busy_a), .spike_out_o(sout_a), .spike_out_valid_o(valid_a),
    .overrun_o(overrun_a), .dbg_pre_cnt_o(dbg_pre_a), .dbg_post_cnt_o(dbg_post_a)
  );

  // ---------------- dut_b (ACC_WIDTH=5, THRESHOLD=20) ----------------
  logic        tick_b, wen_b;
  logic [3:0]  spk_b, waddr_b, wdata_b;
  logic        busy_b, valid_b, overrun_b;
  logic [3:0]  sout_b;
  logic [31:0] dbg_pre_b, dbg_post_b;

  synapse_accum_engine #(.N_PRE(4), .N_POST(4), .W_WIDTH(4), .ACC_WIDTH(5), .THRESHOLD(20)) dut_b (
    .clk_i(clk), .rst_i(rst), .tick_i(tick_b), .spike_in_i(spk_b),
    .w_wr_en_i(wen_b), .w_wr_addr_i(waddr_b), .w_wr_data_i(wdata_b),
    .busy_o(busy_b), .spike_out_o(sout_b), .spike_out_valid_o(valid_b),
    .overrun_o(overrun_b), .dbg_pre_cnt_o(dbg_pre_b), .dbg_post_cnt_o(dbg_post_b)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int passes = 0;

  // Entry: {latency[7:0], spike_out[3:0]}
  logic [11:0] exp_q[$];
  logic [11:0] exp_b_q[$];
  logic [11:0] exp_e_a, exp_e_b;
  int accept_cyc_a = 0;
  int accept_cyc_b = 0;
  int valid_seen_a = 0;
  int valid_seen_b = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, $signed(act), $signed(exp));
  endtask

  // Latency is counted in clock edges from the accepting edge to the edge that samples valid high
  always @(negedge clk) begin
    if (valid_a) begin
      valid_seen_a++;
      if (exp_q.size() == 0) check("unexpected_valid_a", 64'd1, 64'd0);
      else begin
        exp_e_a = exp_q.pop_front();
        check("spike_out_a", 64'(sout_a), 64'(exp_e_a[3:0]));
        check("latency_a", 64'(cyc - accept_cyc_a + 1), 64'(exp_e_a[11:4]));
      end
    end
    if (valid_b) begin
      valid_seen_b++;
      if (exp_b_q.size() == 0) check("unexpected_valid_b", 64'd1, 64'd0);
      else begin
        exp_e_b = exp_b_q.pop_front();
        check("spike_out_b", 64'(sout_b), 64'(exp_e_b[3:0]));
        check("latency_b", 64'(cyc - accept_cyc_b + 1), 64'(exp_e_b[11:4]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wr_a(input int addr, input int data);
    @(negedge clk); wen_a = 1'b1; waddr_a = 4'(addr); wdata_a = 4'(data);
    @(posedge clk); #1 wen_a = 1'b0;
  endtask

  task automatic fill_a(input int lo, input int hi, input int data);
    for (int a = lo; a <= hi; a++) wr_a(a, data);
  endtask

  task automatic fill_b(input int data);
    for (int a = 0; a < 16; a++) begin
      @(negedge clk); wen_b = 1'b1; waddr_b = 4'(a); wdata_b = 4'(data);
      @(posedge clk); #1 wen_b = 1'b0;
    end
  endtask

  // Issue one tick on dut_a.
  // poke_at: negedge index at which tick and a write are pulsed mid-scan.
  // rst_at: negedge index at which reset is pulsed.
  task automatic run_a(input logic [3:0] s, input logic we, input int wa, input int wd,
                       input int poke_at, input int rst_at,
                       input logic [3:0] exp_spk, input int exp_lat);
    bit done = 1'b0;
    if (rst_at == 0) exp_q.push_back({8'(exp_lat), exp_spk});
    @(negedge clk);
    tick_a = 1'b1; spk_a = s; wen_a = we; waddr_a = 4'(wa); wdata_a = 4'(wd);
    accept_cyc_a = cyc + 1;
    @(posedge clk); #1 tick_a = 1'b0; wen_a = 1'b0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (!busy_a) begin done = 1'b1; break; end
      if (n == poke_at) begin
        check("dbg_pre_in_accum", dbg_pre_a, 64'd1);
        check("dbg_post_in_accum", dbg_post_a, 64'd0);
        tick_a = 1'b1; wen_a = 1'b1; waddr_a = 4'd4; wdata_a = 4'h8;
        @(posedge clk); #1 tick_a = 1'b0; wen_a = 1'b0;
      end
      if (n == rst_at) begin
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        done = 1'b1;
        break;
      end
    end
    if (!done) check("timeout_a", 64'd1, 64'd0);
  endtask

  task automatic run_b(input logic [3:0] s, input logic [3:0] exp_spk, input int exp_lat);
    bit done = 1'b0;
    exp_b_q.push_back({8'(exp_lat), exp_spk});
    @(negedge clk);
    tick_b = 1'b1; spk_b = s;
    accept_cyc_b = cyc + 1;
    @(posedge clk); #1 tick_b = 1'b0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (!busy_b) begin done = 1'b1; break; end
    end
    if (!done) check("timeout_b", 64'd1, 64'd0);
  endtask

  task automatic check_v_a(input string tag, input int e0, input int e1, input int e2, input int e3);
    int e[4];
    e = '{e0, e1, e2, e3};
    for (int i = 0; i < 4; i++)
      check($sformatf("%s_v%0d", tag, i), 64'(dut_a.v_q[i]), 64'(e[i]));
  endtask

  task automatic check_v_b(input string tag, input int ev);
    for (int i = 0; i < 4; i++)
      check($sformatf("%s_v%0d", tag, i), 64'(dut_b.v_q[i]), 64'(ev));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    tick_a = 1'b0; wen_a = 1'b0; spk_a = '0; waddr_a = '0; wdata_a = '0;
    tick_b = 1'b0; wen_b = 1'b0; spk_b = '0; waddr_b = '0; wdata_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_busy", 64'(busy_a), 64'd0);
    check("rst_spike_out", 64'(sout_a), 64'd0);
    check("rst_valid", 64'(valid_a), 64'd0);
    check("rst_overrun", 64'(overrun_a), 64'd0);
    check("rst_dbg_pre", dbg_pre_a, 64'd0);
    check("rst_dbg_post", dbg_post_a, 64'd0);
    check_v_a("rst", 0, 0, 0, 0);
    check("rst_busy_b", 64'(busy_b), 64'd0);

    // Saturation: 7+7+7+7 clamps at +15, then -8 x4 from 15 clamps at -16
    fill_b(7);
    run_b(4'hF, 4'h0, 22);
    check_v_b("sat_pos", 15);
    fill_b(8);
    run_b(4'hF, 4'h0, 22);
    check_v_b("sat_neg", -16);

    // All weights +3, two spiking pre neurons: v=6, no fire
    fill_a(0, 15, 3);
    run_a(4'b0101, 1'b0, 0, 0, 0, 0, 4'h0, 14);
    check_v_a("t1", 6, 6, 6, 6);

    // No spikes: shortest scan, potentials untouched
    run_a(4'b0000, 1'b0, 0, 0, 0, 0, 4'h0, 6);
    check_v_a("t2", 6, 6, 6, 6);

    // Same spikes again: v=12 reaches the threshold, all fire and reset
    run_a(4'b0101, 1'b0, 0, 0, 0, 0, 4'hF, 14);
    check_v_a("t3", 0, 0, 0, 0);

    // Mixed signs: W[0][*]=-8, W[1][*]=+2 gives v=-6
    fill_a(0, 3, 8);
    fill_a(4, 7, 2);
    run_a(4'b0011, 1'b0, 0, 0, 0, 0, 4'h0, 14);
    check_v_a("t4", -6, -6, -6, -6);

    // A write in the tick-accept cycle is seen by that scan: W[1][0]=+7
    run_a(4'b0010, 1'b1, 4, 7, 0, 0, 4'h0, 10);
    check_v_a("t5", 1, -4, -4, -4);

    // W[1][*]=+7: post0 lands exactly on the threshold (8) and fires
    fill_a(5, 7, 7);
    run_a(4'b0010, 1'b0, 0, 0, 0, 0, 4'b0001, 10);
    check_v_a("t6", 0, 3, 3, 3);
    check("overrun_before", 64'(overrun_a), 64'd0);

    // Tick plus write (W[1][0]=-8) during ACCUM: both ignored, overrun set
    run_a(4'b0010, 1'b0, 0, 0, 3, 0, 4'b1110, 10);
    check_v_a("t7", 7, 0, 0, 0);
    check("overrun_set", 64'(overrun_a), 64'd1);

    // The dropped write left W[1][0]=+7, so post0 reaches 14 and fires
    run_a(4'b0010, 1'b0, 0, 0, 0, 0, 4'b0001, 10);
    check_v_a("t8", 0, 7, 7, 7);
    check("overrun_sticky", 64'(overrun_a), 64'd1);

    // Reset mid-ACCUM: scan aborted, state cleared, no valid pulse
    run_a(4'b0001, 1'b0, 0, 0, 0, 3, 4'h0, 0);
    @(negedge clk);
    check("mid_rst_busy", 64'(busy_a), 64'd0);
    check("mid_rst_overrun", 64'(overrun_a), 64'd0);
    check("mid_rst_spike_out", 64'(sout_a), 64'd0);
    check("mid_rst_valid", 64'(valid_a), 64'd0);
    check("mid_rst_dbg_post", dbg_post_a, 64'd0);
    check_v_a("mid_rst", 0, 0, 0, 0);

    // Weights survive reset: W[0][*] is still -8
    run_a(4'b0001, 1'b0, 0, 0, 0, 0, 4'h0, 10);
    check_v_a("t10", -8, -8, -8, -8);

    repeat (3) @(negedge clk);
    check("valid_count_a", 64'(valid_seen_a), 64'd9);
    check("exp_q_empty_a", 64'(exp_q.size()), 64'd0);
    check("valid_count_b", 64'(valid_seen_b), 64'd2);
    check("exp_q_empty_b", 64'(exp_b_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, got %0d cycles", cyc);
    $fatal(1, "global timeout");
  end

endmodule
